// File: rtl/la_inst_server.sv
// ============================================================================
// Module      : la_inst_server
// Description : Serves instruction words to the memory controller over the
//               logic-analyzer fetch handshake (la_data_in / la_oenb).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module la_inst_server #(
    parameter int          DEPTH       = 64,
    parameter int          HOLD_CYCLES = 2,
    parameter logic [31:0] NOP_WORD    = 32'h00000013,
    parameter int          AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [31:0]   req_addr,
    output logic [31:0]   la_data_in,
    output logic [31:0]   la_oenb,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic          busy,
    output logic [15:0]   fetch_count,
    output logic [31:0]   served_addr
);

    localparam int            c_CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_CW-1:0] c_HOLD_LOAD = c_CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SERVED = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_pending;
    logic [c_CW-1:0]   r_hold_cnt;
    logic [31:0]       r_data;
    logic [31:0]       r_oenb;
    logic              r_busy;
    logic [15:0]       r_count;
    logic [31:0]       r_served;
    logic [31:0]       r_mem [DEPTH];

    logic              w_in_range;
    logic [31:0]       w_word;
    logic              w_new_addr;

    // Word index is served_addr[31:2]; anything at or beyond DEPTH reads as NOP.
    assign w_in_range = (r_served[31:AW+2] == '0);
    assign w_word     = w_in_range ? r_mem[r_served[AW+1:2]] : NOP_WORD;
    assign w_new_addr = (req_addr != r_served);

    always_ff @(posedge clk) begin
        if (load_we) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pending  <= 1'b1;
            r_hold_cnt <= '0;
            r_data     <= '0;
            r_oenb     <= '1;
            r_busy     <= 1'b0;
            r_count    <= '0;
            r_served   <= '0;
        end else if (!enable) begin
            r_state   <= IDLE;
            r_pending <= 1'b1;
            r_oenb    <= '1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_oenb <= '1;
                    if (r_pending) begin
                        r_served   <= req_addr;
                        r_hold_cnt <= c_HOLD_LOAD;
                        r_pending  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_new_addr) begin
                        r_served   <= req_addr;
                        r_hold_cnt <= c_HOLD_LOAD;
                    end else if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end else begin
                        // Store read happens here, so a same-edge write yields the old word.
                        r_data  <= w_word;
                        r_oenb  <= '0;
                        r_count <= r_count + 16'd1;
                        r_busy  <= 1'b0;
                        r_state <= SERVED;
                    end
                end
                SERVED: begin
                    if (w_new_addr) begin
                        r_oenb     <= '1;
                        r_served   <= req_addr;
                        r_hold_cnt <= c_HOLD_LOAD;
                        r_busy     <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_oenb  <= '1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign la_data_in  = r_data;
    assign la_oenb     = r_oenb;
    assign busy        = r_busy;
    assign fetch_count = r_count;
    assign served_addr = r_served;

endmodule

`default_nettype wire
